// File: rtl/s_axis_mem_mbuf_if.sv
// AXI-Stream bundle feeding the multi-buffer packet writer.
// The master drives tvalid/tdata/tstrb/tlast and the slave returns tready.
interface s_axis_mem_mbuf_if #(
    parameter int DATA_WIDTH = 32
);
    logic                    tvalid;
    logic                    tready;
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tstrb;
    logic                    tlast;

    modport master (output tvalid, output tdata, output tstrb, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tstrb, input tlast, output tready);
endinterface

// File: rtl/s_axis_mem_mbuf.sv
// AXI-Stream to memory packet writer with NUM_BUFS round-robin packet buffers.
// Optional per-packet byte count is enabled by defining S_AXIS_MEM_MBUF_BYTE_COUNT_EN.
module s_axis_mem_mbuf #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_BUFS   = 2,
    localparam int BUF_W     = $clog2(NUM_BUFS),
    localparam int STRB_W    = DATA_WIDTH / 8,
    localparam int BC_W      = ADDR_WIDTH + $clog2(DATA_WIDTH / 8) + 1
) (
    input  logic                        s_axis_aclk,
    input  logic                        s_axis_areset,
    s_axis_mem_mbuf_if.slave            s_axis,
    output logic [STRB_W-1:0]           mem_write_be,
    output logic [BUF_W+ADDR_WIDTH-1:0] mem_write_address,
    output logic [DATA_WIDTH-1:0]       mem_write_data,
    output logic                        rx_start,
    output logic                        rx_done,
    output logic [BUF_W-1:0]            rx_done_buf,
    output logic [ADDR_WIDTH:0]         rx_done_count,
    output logic                        rx_done_trunc,
    input  logic                        buf_release,
    output logic [BUF_W:0]              bufs_free
`ifdef S_AXIS_MEM_MBUF_BYTE_COUNT_EN
    ,
    output logic [BC_W-1:0]             rx_done_bytes
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DROP = 2'd2
    } state_t;

    localparam logic [BUF_W:0]        NUM_BUFS_C = (BUF_W + 1)'(NUM_BUFS);
    localparam logic [ADDR_WIDTH-1:0] PTR_MAX    = '1;

    state_t                      state_q, state_d;
    logic [ADDR_WIDTH-1:0]       ptr_q, ptr_d;
    logic [BUF_W-1:0]            wr_buf_q, wr_buf_d;
    logic [BUF_W:0]              free_q, free_d;
    logic [STRB_W-1:0]           be_q, be_d;
    logic [BUF_W+ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]       data_q, data_d;
    logic                        done_q, done_d;
    logic [BUF_W-1:0]            done_buf_q, done_buf_d;
    logic [ADDR_WIDTH:0]         count_q, count_d;
    logic                        trunc_q, trunc_d;
    logic                        alloc;
    logic                        rel_ok;
    logic                        accept;

`ifdef S_AXIS_MEM_MBUF_BYTE_COUNT_EN
    localparam int POP_W = $clog2(DATA_WIDTH / 8) + 1;

    logic [BC_W-1:0] bytes_acc_q, bytes_acc_d;
    logic [BC_W-1:0] bytes_out_q, bytes_out_d;

    function automatic logic [POP_W-1:0] popcount(input logic [STRB_W-1:0] v);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < STRB_W; i++) begin
            n = n + POP_W'(v[i]);
        end
        return n;
    endfunction
`endif

    assign s_axis.tready = (state_q != IDLE);
    assign accept        = s_axis.tvalid && s_axis.tready;
    assign rel_ok        = buf_release && (free_q != NUM_BUFS_C);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        wr_buf_d   = wr_buf_q;
        be_d       = '0;
        addr_d     = addr_q;
        data_d     = data_q;
        done_d     = 1'b0;
        done_buf_d = done_buf_q;
        count_d    = count_q;
        trunc_d    = trunc_q;
        alloc      = 1'b0;
`ifdef S_AXIS_MEM_MBUF_BYTE_COUNT_EN
        bytes_acc_d = bytes_acc_q;
        bytes_out_d = bytes_out_q;
`endif
        case (state_q)
            IDLE: begin
                if (s_axis.tvalid && (free_q != '0)) begin
                    alloc   = 1'b1;
                    state_d = RECV;
                    ptr_d   = '0;
`ifdef S_AXIS_MEM_MBUF_BYTE_COUNT_EN
                    bytes_acc_d = '0;
`endif
                end
            end
            RECV: begin
                if (accept) begin
                    be_d   = s_axis.tstrb;
                    addr_d = {wr_buf_q, ptr_q};
                    data_d = s_axis.tdata;
                    ptr_d  = ptr_q + 1'b1;
`ifdef S_AXIS_MEM_MBUF_BYTE_COUNT_EN
                    bytes_acc_d = bytes_acc_q + BC_W'(popcount(s_axis.tstrb));
`endif
                    // The last word slot closes the buffer even without tlast;
                    // any remaining beats are swallowed in DROP.
                    if (s_axis.tlast || (ptr_q == PTR_MAX)) begin
                        done_d     = 1'b1;
                        done_buf_d = wr_buf_q;
                        count_d    = {1'b0, ptr_q} + (ADDR_WIDTH + 1)'(1);
                        trunc_d    = !s_axis.tlast;
                        wr_buf_d   = wr_buf_q + 1'b1;
                        state_d    = s_axis.tlast ? IDLE : DROP;
`ifdef S_AXIS_MEM_MBUF_BYTE_COUNT_EN
                        bytes_out_d = bytes_acc_q + BC_W'(popcount(s_axis.tstrb));
`endif
                    end
                end
            end
            DROP: begin
                if (accept && s_axis.tlast) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        free_d = free_q;
        if (alloc && !rel_ok) begin
            free_d = free_q - (BUF_W + 1)'(1);
        end else if (!alloc && rel_ok) begin
            free_d = free_q + (BUF_W + 1)'(1);
        end
    end

    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            wr_buf_q   <= '0;
            free_q     <= NUM_BUFS_C;
            be_q       <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
            done_buf_q <= '0;
            count_q    <= '0;
            trunc_q    <= 1'b0;
`ifdef S_AXIS_MEM_MBUF_BYTE_COUNT_EN
            bytes_acc_q <= '0;
            bytes_out_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            wr_buf_q   <= wr_buf_d;
            free_q     <= free_d;
            be_q       <= be_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            done_q     <= done_d;
            done_buf_q <= done_buf_d;
            count_q    <= count_d;
            trunc_q    <= trunc_d;
`ifdef S_AXIS_MEM_MBUF_BYTE_COUNT_EN
            bytes_acc_q <= bytes_acc_d;
            bytes_out_q <= bytes_out_d;
`endif
        end
    end

    // rx_start is combinational so it marks the allocation cycle itself.
    assign rx_start          = alloc && !s_axis_areset;
    assign mem_write_be      = be_q;
    assign mem_write_address = addr_q;
    assign mem_write_data    = data_q;
    assign rx_done           = done_q;
    assign rx_done_buf       = done_buf_q;
    assign rx_done_count     = count_q;
    assign rx_done_trunc     = trunc_q;
    assign bufs_free         = free_q;
`ifdef S_AXIS_MEM_MBUF_BYTE_COUNT_EN
    assign rx_done_bytes     = bytes_out_q;
`endif

endmodule

// File: doc/s_axis_mem_mbuf.md
S_AXIS_MEM_MBUF -- requirements
Module: s_axis_mem_mbuf

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, stream/memory data width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, word address width per buffer; DEPTH = 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter NUM_BUFS, default 2, packet buffer count (power of 2, 2..8); BUF_W = $clog2(NUM_BUFS).
REQ-004 s_axis_aclk  in  1  sole clock; all logic on rising edge.
REQ-005 s_axis_areset  in  1  reset, synchronous, active-high.
REQ-006 s_axis_tvalid / s_axis_tdata / s_axis_tstrb / s_axis_tlast  in  1 / DATA_WIDTH / DATA_WIDTH/8 / 1  AXI-Stream slave inputs.
REQ-007 s_axis_tready  out  1  stream ready.
REQ-008 mem_write_be  out  DATA_WIDTH/8  byte write enables (all-zero = no write).
REQ-009 mem_write_address  out  BUF_W+ADDR_WIDTH  {buffer index, word pointer}.
REQ-010 mem_write_data  out  DATA_WIDTH  write data.
REQ-011 rx_start  out  1  one-cycle pulse: packet allocated a buffer.
REQ-012 rx_done  out  1  one-cycle pulse: packet stored.
REQ-013 rx_done_buf  out  BUF_W  buffer index of completed packet, valid with rx_done.
REQ-014 rx_done_count  out  ADDR_WIDTH+1  words stored (1..DEPTH), valid with rx_done.
REQ-015 rx_done_trunc  out  1  packet exceeded DEPTH, valid with rx_done.
REQ-016 buf_release  in  1  one-cycle pulse: consumer frees oldest occupied buffer.
REQ-017 bufs_free  out  BUF_W+1  count of free buffers.

Function
REQ-018 States SHALL be IDLE, RECV, DROP; s_axis_tready SHALL be 1 exactly in RECV and DROP.
REQ-019 IDLE->RECV when s_axis_tvalid=1 and bufs_free>0; that cycle rx_start=1, bufs_free decrements, word pointer clears, current buffer = wr_buf.
REQ-020 IDLE with bufs_free=0 SHALL hold, tready=0, rx_start=0.
REQ-021 Accepted beat (tvalid & tready) in RECV SHALL write next cycle: be=tstrb, address={wr_buf,ptr}, data=tdata; ptr increments.
REQ-022 RECV beat with tlast=1 -> IDLE; next cycle rx_done=1, count=ptr+1, trunc=0; wr_buf advances modulo NUM_BUFS.
REQ-023 RECV beat at ptr=DEPTH-1 with tlast=0 -> DROP; next cycle rx_done=1, count=DEPTH, trunc=1; wr_buf advances.
REQ-024 RECV beat at ptr=DEPTH-1 with tlast=1 SHALL follow REQ-022 (count=DEPTH, trunc=0).
REQ-025 DROP SHALL accept and discard beats (mem_write_be=0) until tlast accepted, then -> IDLE; no second rx_done.
REQ-026 mem_write_be SHALL be 0 in every cycle not following an accepted RECV beat.
REQ-027 buf_release with bufs_free<NUM_BUFS SHALL increment bufs_free; with bufs_free=NUM_BUFS SHALL be ignored.
REQ-028 Simultaneous allocation and release SHALL leave bufs_free unchanged.
REQ-029 Buffers SHALL be allocated and released in strict round-robin order starting at index 0.

Reset
REQ-030 On s_axis_areset=1: state=IDLE, wr_buf=0, ptr=0, bufs_free=NUM_BUFS, tready=0, mem_write_be=0, rx_start=0, rx_done=0, rx_done_buf=0, rx_done_count=0, rx_done_trunc=0.
REQ-031 Reset mid-packet SHALL abandon it with no rx_done; mem_write_address/data reset values are don't-care.

Configuration
REQ-032 Macro S_AXIS_MEM_MBUF_BYTE_COUNT_EN defined: output rx_done_bytes (ADDR_WIDTH+$clog2(DATA_WIDTH/8)+1 bits) SHALL give popcount of tstrb over stored beats, valid with rx_done, reset 0.
REQ-033 Macro undefined: port rx_done_bytes and its counter SHALL not exist; all other behaviour identical.

Verification (DATA_WIDTH=32, ADDR_WIDTH=3, NUM_BUFS=2)
REQ-034 3-beat packet, tlast on beat 3 -> writes at addresses 0,1,2; rx_done with buf=0, count=3, trunc=0; bufs_free=1.
REQ-035 10-beat packet -> 8 writes at 0..7; rx_done count=8, trunc=1; beats 9-10 accepted, be=0; then IDLE.
REQ-036 Three 2-beat packets, no release -> packets 1,2 at 0..1 and 8..9; packet 3 tready=0 until buf_release, then written at 0..1.
REQ-037 bufs_free=1, buf_release same cycle as rx_start -> bufs_free stays 1.
REQ-038 Reset after 2 beats of packet -> no rx_done, bufs_free=2; next packet written at address 0.
REQ-039 Macro defined: beats tstrb 4'b1111, 4'b0011 (tlast) -> rx_done_bytes=6, rx_done_count=2.
